// File: rtl/apb_ctrl_pkg.sv
// Shared definitions for the APB master arbiter slice.
//   apb_state_t : transfer sequencer states (IDLE / SETUP / ACCESS)
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
//   wait_cnt_w() : width of the ACCESS wait counter for a given timeout
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // At least one bit so the counter exists even with the timeout disabled.
  function automatic int unsigned wait_cnt_w(input int unsigned timeout_cycles);
    int unsigned w;
    w = $clog2(timeout_cycles + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick.
//   req   : request vector
//   ptr   : highest-priority index this round
//   grant : one-hot grant (zero when no request)
//   idx   : index of the granted requester
//   any   : at least one request present
module apb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin : pick
    logic [IDX_W:0] c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = '0;
    // Scan ptr, ptr+1, ... wrapping; one extra bit keeps ptr+i from overflowing.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      c = {1'b0, ptr} + (IDX_W+1)'(i);
      if (c >= (IDX_W+1)'(NUM_REQ)) c = c - (IDX_W+1)'(NUM_REQ);
      if (!any && req[c[IDX_W-1:0]]) begin
        any                = 1'b1;
        grant[c[IDX_W-1:0]] = 1'b1;
        idx                = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters (round-robin).
//   clk, rst                : clock, asynchronous active-high reset
//   req_valid/ready         : per-requester handshake (ready only in IDLE)
//   req_write/addr/wdata    : packed request fields, requester i at slice i
//   rsp_valid               : one-hot, one-cycle completion pulse
//   rsp_rdata/slverr/timeout: registered completion status, zero when idle
//   psel..pwdata            : APB master outputs
//   prdata, pready, pslverr : APB slave inputs, sampled only in ACCESS
module apb_master_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = wait_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  apb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  ptr, cur, arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic              arb_any;
  logic [CNT_W-1:0]  wcnt;
  logic              accept, done, abort;

  apb_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(arb_grant),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (pready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && wcnt == CNT_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Gated by rst so the combinational accept path is quiet during reset too.
    req_ready = (accept && !rst) ? arb_grant : '0;
    psel      = (state == SETUP) || (state == ACCESS);
    penable   = (state == ACCESS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      cur         <= '0;
      wcnt        <= '0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      if (accept) begin
        paddr  <= req_addr[arb_idx*ADDR_W +: ADDR_W];
        pwdata <= req_wdata[arb_idx*DATA_W +: DATA_W];
        pwrite <= req_write[arb_idx];
        cur    <= arb_idx;
        ptr    <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
      if (state == ACCESS) begin
        if (done || abort) wcnt <= '0;
        else               wcnt <= wcnt + 1'b1;
      end
      if (done) begin
        rsp_valid[cur] <= 1'b1;
        rsp_rdata      <= pwrite ? '0 : prdata;
        rsp_slverr     <= pslverr;
      end
      if (abort) begin
        rsp_valid[cur] <= 1'b1;
        rsp_slverr     <= 1'b1;
        rsp_timeout    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: stimulus/model pushes expected
// completions, a monitor pops them on rsp_valid, and an APB slave model
// serves planned wait states and data.
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0, req_ready, req_write = '0, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0]   rsp_rdata, prdata = '0, pwdata;
  logic [AW-1:0]   paddr;
  logic            rsp_slverr, rsp_timeout, psel, penable, pwrite;
  logic            pready = 1'b0, pslverr = 1'b0;

  apb_master_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            w;      // ACCESS cycles with pready=0 before completing
    logic [DW-1:0] rdata;
    logic          err;
  } plan_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
    int            cyc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    gl_idx[$];
  int    gl_cyc[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int ptr_m = 0, free_at = 0;
  int gen_mode = 0;              // 0 none, 1 random, 2 always valid
  logic [N-1:0] granted = '0;
  logic          fx_en = 1'b0, fx_err = 1'b0;
  int            fx_w = 0;
  logic [DW-1:0] fx_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic new_req(input int i);
    req_valid[i]          = 1'b1;
    req_write[i]          = 1'($urandom_range(0, 1));
    req_addr[i*AW +: AW]  = $urandom;
    req_wdata[i*DW +: DW] = $urandom;
  endtask

  task automatic post(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Model: the bus is free from the cycle the previous response appears.
  task automatic check_ready();
    logic [N-1:0] expv;
    int g, r;
    plan_t p;
    exp_t e;
    expv = '0;
    g    = -1;
    if (cyc >= free_at) g = rr_pick(req_valid, ptr_m);
    if (g >= 0) expv[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(expv));
    if (g >= 0) begin
      granted[g] = 1'b1;
      ptr_m      = (g + 1) % N;
      p.idx   = g;
      p.wr    = req_write[g];
      p.addr  = req_addr[g*AW +: AW];
      p.wdata = req_wdata[g*DW +: DW];
      if (fx_en) begin
        p.w = fx_w; p.rdata = fx_rdata; p.err = fx_err;
      end else begin
        r = int'($urandom_range(0, 19));
        if (r < 12)       p.w = 0;
        else if (r < 17)  p.w = int'($urandom_range(1, 4));
        else if (r == 17) p.w = T - 1;
        else if (r == 18) p.w = T;
        else              p.w = T + 3;
        p.rdata = $urandom;
        p.err   = ($urandom_range(0, 7) == 0);
      end
      plan_q.push_back(p);
      e.idx   = g;
      e.to    = (p.w >= T);
      e.err   = e.to ? 1'b1 : p.err;
      e.rdata = (e.to || p.wr) ? '0 : p.rdata;
      e.cyc   = e.to ? cyc + 2 + T : cyc + 3 + p.w;
      free_at = e.cyc;
      exp_q.push_back(e);
      gl_idx.push_back(g);
      gl_cyc.push_back(cyc);
    end
  endtask

  task automatic tick_begin();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (granted[i]) begin
        req_valid[i] = 1'b0;
        granted[i]   = 1'b0;
        if (gen_mode == 2) new_req(i);
      end else if (gen_mode == 1) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) new_req(i);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end else if (gen_mode == 2 && !req_valid[i]) begin
        new_req(i);
      end
    end
  endtask

  task automatic tick_end();
    #1;
    check_ready();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick_begin();
      tick_end();
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick_begin();
      req_valid = '0;
      tick_end();
    end
  endtask

  // APB slave model: serves the plan popped at SETUP.
  plan_t pl_cur;
  logic  pl_have = 1'b0;
  int    acc_k = 0;
  always @(negedge clk) begin
    if (rst) begin
      plan_q.delete();
      pl_have = 1'b0;
      acc_k   = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
    end else if (psel && !penable) begin
      if (plan_q.size() == 0) begin
        chk("apb_setup_unplanned", 64'(psel), 64'(0));
        pl_have = 1'b0;
      end else begin
        pl_cur  = plan_q.pop_front();
        pl_have = 1'b1;
        chk("setup_paddr", 64'(paddr), 64'(pl_cur.addr));
        chk("setup_pwrite", 64'(pwrite), 64'(pl_cur.wr));
        chk("setup_pwdata", 64'(pwdata), 64'(pl_cur.wdata));
      end
      acc_k   = 0;
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
    end else if (psel && penable) begin
      chk("access_planned", 64'(pl_have), 64'(1));
      chk("access_paddr", 64'(paddr), 64'(pl_cur.addr));
      chk("access_pwrite", 64'(pwrite), 64'(pl_cur.wr));
      chk("access_pwdata", 64'(pwdata), 64'(pl_cur.wdata));
      if (acc_k == pl_cur.w) begin
        pready  = 1'b1;
        prdata  = pl_cur.rdata;
        pslverr = pl_cur.err;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
      end
      acc_k++;
    end else begin
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
    end
  end

  // Response monitor.
  exp_t me;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        me = exp_q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(1) << me.idx);
        chk("rsp_rdata", 64'(rsp_rdata), 64'(me.rdata));
        chk("rsp_slverr", 64'(rsp_slverr), 64'(me.err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(me.to));
        chk("rsp_cycle", 64'(cyc), 64'(me.cyc));
      end
    end else begin
      chk("rsp_idle_zero", 64'({rsp_rdata, rsp_slverr, rsp_timeout}), 64'(0));
      if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
        chk("rsp_missing", 64'(0), 64'(1));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset: outputs quiet even with a request pending.
    rst = 1'b1;
    req_valid[1] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", 64'({req_ready, rsp_valid, rsp_slverr, rsp_timeout, psel, penable}), 64'(0));
    chk("reset_apb", 64'({pwrite, paddr}), 64'(0));
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    idle_ticks(2);

    // All requesters continuously valid: 0,1,2,3,0 back to back.
    fx_en = 1'b1; fx_w = 0; fx_err = 1'b0; fx_rdata = 32'h1234_5678;
    gl_idx.delete(); gl_cyc.delete();
    gen_mode = 2;
    ticks(13);
    gen_mode = 0;
    idle_ticks(6);
    chk("rr_count_ge5", 64'(gl_idx.size() >= 5), 64'(1));
    for (int k = 0; k < 5 && k < gl_idx.size(); k++) begin
      chk("rr_order", 64'(gl_idx[k]), 64'(exp_order[k]));
      if (k > 0) chk("rr_gap", 64'(gl_cyc[k] - gl_cyc[k-1]), 64'(3));
    end

    // Single zero-wait write from requester 0.
    tick_begin(); post(0, 1'b1, 32'h10, 32'hA5A5_A5A5); tick_end();
    tick_begin(); chk("t1_setup", 64'({psel, penable}), 64'(2'b10)); tick_end();
    tick_begin(); chk("t1_access", 64'({psel, penable}), 64'(2'b11)); tick_end();
    tick_begin(); chk("t1_done_bus", 64'({psel, penable}), 64'(0)); tick_end();
    idle_ticks(2);

    // Read with 3 wait states.
    fx_w = 3; fx_rdata = 32'hDEAD_BEEF;
    tick_begin(); post(1, 1'b0, 32'h0000_0400, 32'h0); tick_end();
    idle_ticks(8);

    // Slave error on a zero-wait write.
    fx_w = 0; fx_err = 1'b1;
    tick_begin(); post(2, 1'b1, 32'h0000_0800, 32'h5555_AAAA); tick_end();
    idle_ticks(5);
    fx_err = 1'b0;

    // Timeout, then the last non-timeout wait count, then a normal read.
    fx_w = T; fx_rdata = 32'hCAFE_F00D;
    tick_begin(); post(3, 1'b0, 32'h0000_0C00, 32'h0); tick_end();
    idle_ticks(T + 4);
    fx_w = T - 1;
    tick_begin(); post(0, 1'b0, 32'h0000_0C04, 32'h0); tick_end();
    idle_ticks(T + 4);
    fx_w = 0;
    tick_begin(); post(3, 1'b0, 32'h0000_0C08, 32'h0); tick_end();
    idle_ticks(5);

    // Randomized traffic.
    fx_en = 1'b0;
    gen_mode = 1;
    ticks(1500);
    gen_mode = 0;
    idle_ticks(T + 6);

    // Reset in the middle of ACCESS.
    fx_en = 1'b1; fx_w = 10;
    tick_begin(); post(2, 1'b1, 32'h0000_1000, 32'h0BAD_0BAD); tick_end();
    idle_ticks(2);
    chk("pre_rst_access", 64'({psel, penable}), 64'(2'b11));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_bus_idle", 64'({psel, penable}), 64'(0));
    chk("rst_outs", 64'({req_ready, rsp_valid, rsp_slverr, rsp_timeout}), 64'(0));
    free_at = 0; ptr_m = 0; granted = '0; req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_ticks(8);
    fx_w = 0;
    tick_begin(); post(1, 1'b0, 32'h20, 32'h0); post(3, 1'b0, 32'h30, 32'h0); tick_end();
    chk("post_rst_grant", 64'(gl_idx[gl_idx.size()-1]), 64'(1));
    idle_ticks(4);
    ticks(4);
    idle_ticks(6);

    // More random traffic, then drain.
    fx_en = 1'b0;
    gen_mode = 1;
    ticks(400);
    gen_mode = 0;
    for (int n = 0; n < 300 && exp_q.size() > 0; n++) idle_ticks(1);
    idle_ticks(2);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
